// File: rtl/fp_to_int_iter_if.sv
// Operand/result handshake bundle for the float-to-int converter.
// The producer/consumer side uses master; the converter uses slave.
interface fp_to_int_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_flags;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_flags
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_flags
    );
endinterface

// File: rtl/fp_to_int_iter.sv
// Iterative IEEE-754 single to signed 32-bit integer, round toward zero.
// The significand is walked to its integer position STEP bits per cycle.
module fp_to_int_iter #(
    parameter int STEP = 4
) (
    input  logic              clk,
    input  logic              rst,
    fp_to_int_iter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, FINISH, HOLD} state_t;

    localparam logic [5:0] STEP_W = 6'(STEP);

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [5:0]  count_q, count_d;
    logic        dir_left_q, dir_left_d;
    logic        sticky_q, sticky_d;
    logic        sign_q, sign_d;
    logic        nv_q, nv_d;
    logic [31:0] out_data_q, out_data_d;
    logic [1:0]  out_flags_q, out_flags_d;
    logic        out_valid_q, out_valid_d;

    logic [7:0]  exp_f;
    logic [22:0] mant_f;
    logic        sign_f;
    logic        is_min_int;
    logic [31:0] sat_val;
    logic [5:0]  k;
    logic [31:0] low_mask;

    assign exp_f      = bus.in_data[30:23];
    assign mant_f     = bus.in_data[22:0];
    assign sign_f     = bus.in_data[31];
    assign is_min_int = (bus.in_data == 32'hCF00_0000);
    // NaN always saturates positive; everything else by sign
    assign sat_val    = (sign_f && !(exp_f == 8'hFF && mant_f != 23'd0)) ? 32'h8000_0000
                                                                         : 32'h7FFF_FFFF;
    assign k          = (count_q > STEP_W) ? STEP_W : count_q;
    assign low_mask   = 32'((64'd1 << k) - 64'd1);

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_flags = out_flags_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        dir_left_d  = dir_left_q;
        sticky_d    = sticky_q;
        sign_d      = sign_q;
        nv_d        = nv_q;
        out_data_d  = out_data_q;
        out_flags_d = out_flags_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sticky_d = 1'b0;
                    nv_d     = 1'b0;
                    sign_d   = 1'b0;
                    count_d  = 6'd0;
                    state_d  = FINISH;
                    if (exp_f == 8'hFF || (exp_f >= 8'd158 && !is_min_int)) begin
                        // Saturated result is loaded as final value, sign already applied
                        acc_d = sat_val;
                        nv_d  = 1'b1;
                    end else if (exp_f < 8'd127) begin
                        acc_d    = 32'd0;
                        sticky_d = (exp_f != 8'd0) || (mant_f != 23'd0);
                    end else begin
                        acc_d  = {8'd0, 1'b1, mant_f};
                        sign_d = sign_f;
                        if (exp_f > 8'd150) begin
                            dir_left_d = 1'b1;
                            count_d    = 6'(exp_f - 8'd150);
                        end else begin
                            dir_left_d = 1'b0;
                            count_d    = 6'(8'd150 - exp_f);
                        end
                        if (exp_f != 8'd150)
                            state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (dir_left_q) begin
                    acc_d = acc_q << k;
                end else begin
                    acc_d    = acc_q >> k;
                    sticky_d = sticky_q | (|(acc_q & low_mask));
                end
                count_d = count_q - k;
                if (count_q == k)
                    state_d = FINISH;
            end
            FINISH: begin
                out_data_d  = sign_q ? (-acc_q) : acc_q;
                out_flags_d = {nv_q, sticky_q};
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= 32'd0;
            count_q     <= 6'd0;
            dir_left_q  <= 1'b0;
            sticky_q    <= 1'b0;
            sign_q      <= 1'b0;
            nv_q        <= 1'b0;
            out_data_q  <= 32'd0;
            out_flags_q <= 2'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            dir_left_q  <= dir_left_d;
            sticky_q    <= sticky_d;
            sign_q      <= sign_d;
            nv_q        <= nv_d;
            out_data_q  <= out_data_d;
            out_flags_q <= out_flags_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_fp_to_int_iter.sv
// Random and directed float-to-int conversions checked against an
// arithmetic model of truncating fcvt.w.s, including latency and backpressure.
module tb_fp_to_int_iter;
    localparam int STEP = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    fp_to_int_iter_if bus ();

    fp_to_int_iter #(.STEP(STEP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Value = sig * 2^(e-23); truncate toward zero, saturate outside int32.
    task automatic ref_model(input logic [31:0] f, output logic [31:0] r,
                             output logic [1:0] fl, output int lat);
        int     ex;
        int     e;
        longint sig;
        longint mag;
        logic   s;
        logic   nx;
        ex  = int'(f[30:23]);
        e   = ex - 127;
        s   = f[31];
        sig = longint'({(ex != 0), f[22:0]});
        lat = 1;
        if (ex == 255) begin
            r  = (f[22:0] != 0 || !s) ? 32'h7FFF_FFFF : 32'h8000_0000;
            fl = 2'b10;
        end else if (e < 0) begin
            r  = 32'd0;
            fl = {1'b0, (f[30:0] != 31'd0)};
        end else begin
            if (e >= 23) begin
                mag = (e > 40) ? (64'sd1 <<< 41) : (sig <<< (e - 23));
                nx  = 1'b0;
            end else begin
                mag = sig >>> (23 - e);
                nx  = (sig % (64'sd1 <<< (23 - e))) != 0;
            end
            if (mag > 64'sd2147483648 || (mag == 64'sd2147483648 && !s)) begin
                r  = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
                fl = 2'b10;
            end else begin
                r   = s ? 32'(-mag) : 32'(mag);
                fl  = {1'b0, nx};
                lat = 1 + (((e > 23) ? e - 23 : 23 - e) + STEP - 1) / STEP;
            end
        end
    endtask

    // Entered just after a rising edge with the DUT idle.
    task automatic conv(input logic [31:0] din, input int hold);
        logic [31:0] er;
        logic [1:0]  ef;
        int          el;
        int          lat;
        ref_model(din, er, ef, el);
        bus.in_data   = din;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) bus.in_data = $urandom;
        end
        chk("latency", 32'(lat), 32'(el));
        if (!bus.out_valid) return;
        chk("out_data", bus.out_data, er);
        chk("out_flags", 32'(bus.out_flags), 32'(ef));
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = $urandom;
            @(posedge clk); #1;
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_data", bus.out_data, er);
            chk("hold_flags", 32'(bus.out_flags), 32'(ef));
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("rel_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rel_in_ready_next", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] dir_vec [0:11];
        logic [31:0] v;
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'd0;
        bus.out_ready = 1'b0;
        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_out_flags", 32'(bus.out_flags), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        dir_vec = '{32'h40490FDB, 32'hC2F60000, 32'h4B000001, 32'h4F000000,
                    32'hCF000000, 32'h7FC00000, 32'hFF800000, 32'h3F000000,
                    32'h00000000, 32'h80000001, 32'h80000000, 32'h4EFFFFFF};
        foreach (dir_vec[i]) conv(dir_vec[i], (i == 0) ? 5 : 0);

        // Reset in the middle of SHIFT drops the conversion
        bus.in_data  = 32'h40490FDB;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("midrst_quiet", 32'(bus.out_valid), 32'd0);
        end
        conv(32'h42F60000, 0);

        for (int n = 0; n < 300; n++) begin
            v = $urandom;
            if (n % 2 == 0) v[30:23] = 8'(120 + $urandom_range(0, 40));
            conv(v, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
